cmp_scan_scheduler: RTL and testbench
=====================================

# cmp_scan_scheduler

Sequences the shared comparator drive control (T/D) and time-shares the single GTH TX word stream among the AnalogCMP pad channels. For each enabled pad in round-robin order it drives the pad, releases it, then captures a burst of 72 comparator samples. It packs the samples with a header into one 80-bit word and hands that word to the TX path with a valid/ready handshake. It sits in the `sample_clk` domain, between the registered `cmp_data_*` bits and the GTH TX data input (through the downstream clock-crossing FIFO).

## Interface
Parameters:
- `NUM_PADS`, 3, number of comparator channels (1..4; the pad index field is 2 bits)
- `DRIVE_CYCLES`, 4, cycles the pad is actively driven (≥1)
- `SETTLE_CYCLES`, 2, cycles after release before capture starts (≥1)

Ports:
- `sample_clk`  in  1  sole clock; every register is in this domain
- `sample_rst_n`  in  1  synchronous reset, active-low
- `enable`  in  1  run request; level-sensitive
- `pad_mask`  in  NUM_PADS  per-pad enable; sampled in SELECT
- `cmp_data`  in  NUM_PADS  registered comparator outputs, bit i = pad i
- `T`  out  1  comparator driver enable, active-low (0 = driving)
- `D`  out  1  comparator drive value
- `tx_data`  out  80  packed word
- `tx_valid`  out  1  word available
- `tx_ready`  in  1  downstream accepts the word
- `cur_pad`  out  2  pad index currently served
- `busy`  out  1  FSM is not in IDLE
- `word_done`  out  1  one-cycle pulse on each accepted word

## Operation
- Reset values (applied on any clock edge with `sample_rst_n`=0, including mid-burst): `T`=1, `D`=0, `tx_data`=0, `tx_valid`=0, `cur_pad`=0, `busy`=0, `word_done`=0.
- Reset also clears internal state: `seq`=0, `last_pad`=NUM_PADS-1, FSM=IDLE.
- **IDLE**
  - Outputs: `T`=1, `D`=0.
  - Transition to SELECT when `enable`=1 and |`pad_mask`=1.
- **SELECT** (1 cycle)
  - Pick the next pad strictly after `last_pad` with its mask bit set, wrapping to 0.
  - Load `cur_pad` with that pad and update `last_pad`.
  - If `enable`=0 or the mask is all zero, return to IDLE with no word produced.
- **DRIVE** (DRIVE_CYCLES cycles)
  - Outputs: `T`=0, `D`=1.
- **SETTLE** (SETTLE_CYCLES cycles)
  - Outputs: `T`=1, `D`=0.
- **CAPTURE** (72 cycles)
  - Shift in `cmp_data[cur_pad]` each cycle.
  - The first sample lands in word bit 71 and the last in bit 0.
- **EMIT**
  - `tx_data` = {4'hA, `cur_pad`[1:0], `seq`[1:0], samples[71:0]}, with `tx_valid`=1.
  - Hold `tx_data` stable until `tx_ready`=1.
  - On the handshake: `word_done`=1 for one cycle, `seq` increments (wraps 3→0), `tx_valid` drops, then go to SELECT.
- Deasserting `enable` mid-burst does not abort: the current word completes and is emitted, and SELECT then goes to IDLE.
- `pad_mask` changes take effect only at the next SELECT.
- `busy` = (state != IDLE).

## Timing
- Latency from SELECT entry to `tx_valid` rise = 1 + DRIVE_CYCLES + SETTLE_CYCLES + 72 cycles (79 with defaults).
- The back-to-back word period with `tx_ready` held at 1 is 80 cycles with defaults (79 + 1 handshake cycle).
- `T` and `D` are registered and change on the cycle the FSM enters the corresponding state.
- `D`=1 only while `T`=0.
- Capture samples `cmp_data` on the same edge that counts each CAPTURE cycle: 72 samples, no skips, no duplicates.
- `tx_ready` while `tx_valid`=0 is ignored.
- `tx_ready` held low stalls the FSM in EMIT indefinitely with `T`=1, `D`=0.
- All counters (drive, settle, capture) reload at state entry; no count carries across words.
- A single-pad mask serves the same pad every word; `seq` still increments.

## Test plan
- Reset, `enable`=1, mask=3'b111, `cmp_data`=3'b010 constant, `tx_ready`=1 → first word `tx_data`=80'hA0_000000000000000000 (pad 0, seq 0). Next word: header 8'hA5 with 72 ones. Next: 8'hAA with all zeros. `tx_valid` rises 79 cycles after SELECT.
- Check T/D waveform with defaults → `T`=0/`D`=1 for exactly 4 cycles, then `T`=1/`D`=0 for 2 + 72 cycles before `tx_valid`.
- Mask=3'b101, 5 words → pad sequence 0,2,0,2,0; `seq` 0,1,2,3,0 (wrap).
- `tx_ready`=0 for 20 cycles in EMIT → `tx_data` stable and `tx_valid` held. `word_done` pulses once, on the cycle `tx_ready`=1.
- Drop `enable` during CAPTURE → the word still emits; the FSM then returns to IDLE with `busy`=0. Mask=0 with `enable`=1 → stays in IDLE, no `tx_valid`.
- Assert `sample_rst_n`=0 for one cycle mid-DRIVE → next cycle `T`=1, `D`=0, `tx_valid`=0. After release, the first word comes from pad 0 with seq 0.

Source files
------------

// File: rtl/cmp_scan_scheduler.sv
// Round-robin comparator pad scanner: drive, settle, capture 72 samples,
// then emit one 80-bit header+payload word over a valid/ready handshake.
module cmp_scan_scheduler #(
    parameter int NUM_PADS      = 3,
    parameter int DRIVE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                sample_clk,
    input  logic                sample_rst_n,
    input  logic                enable,
    input  logic [NUM_PADS-1:0] pad_mask,
    input  logic [NUM_PADS-1:0] cmp_data,
    output logic                T,
    output logic                D,
    output logic [79:0]         tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [1:0]          cur_pad,
    output logic                busy,
    output logic                word_done
);

    typedef enum logic [2:0] {
        IDLE, SELECT, DRIVE, SETTLE, CAPTURE, EMIT
    } state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [1:0]  last_pad, seq, next_pad, idx2;
    logic        have_pad, sample_bit, accept;
    logic [71:0] shift, shift_n;
    logic [3:0]  mask_ext, cmp_ext;
    int          idx;

    assign mask_ext = 4'(pad_mask);
    assign cmp_ext  = 4'(cmp_data);
    assign busy     = (state != IDLE);

    // Nearest set mask bit strictly after last_pad, wrapping; lowest k wins.
    always_comb begin
        next_pad = '0;
        have_pad = 1'b0;
        idx      = 0;
        idx2     = '0;
        for (int k = NUM_PADS; k >= 1; k--) begin
            idx  = (int'(last_pad) + k) % NUM_PADS;
            idx2 = 2'(idx);
            if (mask_ext[idx2]) begin
                next_pad = idx2;
                have_pad = 1'b1;
            end
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        accept     = (state == EMIT) && tx_valid && tx_ready;
        sample_bit = cmp_ext[cur_pad];
        shift_n    = {shift[70:0], sample_bit};
        unique case (state)
            IDLE: begin
                if (enable && (|pad_mask))
                    state_n = SELECT;
            end
            SELECT: begin
                if (enable && have_pad) begin
                    state_n = DRIVE;
                    cnt_n   = 8'(DRIVE_CYCLES - 1);
                end else begin
                    state_n = IDLE;
                end
            end
            DRIVE: begin
                if (cnt == 8'd0) begin
                    state_n = SETTLE;
                    cnt_n   = 8'(SETTLE_CYCLES - 1);
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            SETTLE: begin
                if (cnt == 8'd0) begin
                    state_n = CAPTURE;
                    cnt_n   = 8'd71;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            CAPTURE: begin
                if (cnt == 8'd0)
                    state_n = EMIT;
                else
                    cnt_n = cnt - 8'd1;
            end
            EMIT: begin
                if (accept)
                    state_n = SELECT;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sample_clk) begin
        if (!sample_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            T         <= 1'b1;
            D         <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            cur_pad   <= '0;
            word_done <= 1'b0;
            seq       <= '0;
            last_pad  <= 2'(NUM_PADS - 1);
            shift     <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            // Registered drive pins follow the state being entered.
            T         <= (state_n != DRIVE);
            D         <= (state_n == DRIVE);
            word_done <= accept;
            if (state == SELECT && state_n == DRIVE) begin
                cur_pad  <= next_pad;
                last_pad <= next_pad;
            end
            if (state == CAPTURE)
                shift <= shift_n;
            if (state == CAPTURE && state_n == EMIT) begin
                tx_data  <= {4'hA, cur_pad, seq, shift_n};
                tx_valid <= 1'b1;
            end
            if (accept) begin
                tx_valid <= 1'b0;
                seq      <= seq + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_cmp_scan_scheduler.sv
// Directed bench for cmp_scan_scheduler: word format, timing, handshake,
// round-robin order, enable/mask behaviour and synchronous reset.
module tb_cmp_scan_scheduler;

    logic        sample_clk;
    logic        sample_rst_n;
    logic        enable;
    logic [2:0]  pad_mask;
    logic [2:0]  cmp_data;
    logic        T;
    logic        D;
    logic [79:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  cur_pad;
    logic        busy;
    logic        word_done;

    int tests;
    int fails;

    cmp_scan_scheduler #(
        .NUM_PADS(3),
        .DRIVE_CYCLES(4),
        .SETTLE_CYCLES(2)
    ) dut (
        .sample_clk(sample_clk),
        .sample_rst_n(sample_rst_n),
        .enable(enable),
        .pad_mask(pad_mask),
        .cmp_data(cmp_data),
        .T(T),
        .D(D),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .cur_pad(cur_pad),
        .busy(busy),
        .word_done(word_done)
    );

    initial sample_clk = 1'b0;
    always #5 sample_clk = ~sample_clk;

    task automatic do_reset();
        sample_rst_n = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge sample_clk);
        sample_rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int max, output int n, output bit to);
        n = 0;
        to = 1'b1;
        while (n < max) begin
            @(negedge sample_clk);
            n++;
            if (tx_valid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int max, output bit to);
        int n;
        n = 0;
        to = 1'b1;
        while (n < max) begin
            @(negedge sample_clk);
            n++;
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        sample_rst_n = 1'b0;
        enable = 1'b0;
        pad_mask = 3'b111;
        cmp_data = 3'b000;
        tx_ready = 1'b0;
        repeat (2) @(negedge sample_clk);
        tests++;
        if ({T, D, tx_valid, busy, word_done, cur_pad} !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_outs got T=%b D=%b v=%b busy=%b wd=%b pad=%0d want 1 0 0 0 0 0",
                     T, D, tx_valid, busy, word_done, cur_pad);
        end
        tests++;
        if (tx_data !== 80'h0) begin
            fails++;
            $display("FAIL reset_data got %h want 0", tx_data);
        end
        sample_rst_n = 1'b1;
        @(negedge sample_clk);
    endtask

    task automatic test_first_words();
        int n;
        bit to;
        do_reset();
        pad_mask = 3'b111;
        cmp_data = 3'b010;
        tx_ready = 1'b1;
        enable = 1'b1;
        @(negedge sample_clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL select_busy got %b want 1", busy);
        end
        wait_valid(200, n, to);
        tests++;
        if (to || n != 79) begin
            fails++;
            $display("FAIL first_latency got %0d (timeout=%0d) want 79", n, to);
        end
        tests++;
        if (tx_data !== {8'hA0, 72'h0}) begin
            fails++;
            $display("FAIL word0 got %h want %h", tx_data, {8'hA0, 72'h0});
        end
        @(negedge sample_clk);
        tests++;
        if (word_done !== 1'b1 || tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL word0_accept got wd=%b v=%b want 1 0", word_done, tx_valid);
        end
        wait_valid(200, n, to);
        tests++;
        if (to || n != 79) begin
            fails++;
            $display("FAIL word_period got %0d want 80", n + 1);
        end
        tests++;
        if (tx_data !== {8'hA5, {72{1'b1}}}) begin
            fails++;
            $display("FAIL word1 got %h want %h", tx_data, {8'hA5, {72{1'b1}}});
        end
        wait_valid(200, n, to);
        tests++;
        if (to || tx_data !== {8'hAA, 72'h0}) begin
            fails++;
            $display("FAIL word2 got %h want %h", tx_data, {8'hAA, 72'h0});
        end
        enable = 1'b0;
        wait_idle(200, to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL first_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_td_waveform();
        int idx;
        int drv;
        int first;
        int post;
        int bad;
        do_reset();
        pad_mask = 3'b111;
        cmp_data = 3'b000;
        tx_ready = 1'b1;
        enable = 1'b1;
        @(negedge sample_clk);
        idx = 0;
        drv = 0;
        first = -1;
        post = 0;
        bad = 0;
        while (idx < 200) begin
            if (tx_valid) break;
            if (!T && D) begin
                drv++;
                if (first < 0) first = idx;
            end
            if (T && !D && idx >= 5) post++;
            if (T == D) bad++;
            @(negedge sample_clk);
            idx++;
        end
        tests++;
        if (idx != 79 || drv != 4 || first != 1) begin
            fails++;
            $display("FAIL td_drive got lat=%0d drive=%0d first=%0d want 79 4 1", idx, drv, first);
        end
        tests++;
        if (post != 74 || bad != 0) begin
            fails++;
            $display("FAIL td_release got rel=%0d bad=%0d want 74 0", post, bad);
        end
        tests++;
        if (T !== 1'b1 || D !== 1'b0) begin
            fails++;
            $display("FAIL td_emit got T=%b D=%b want 1 0", T, D);
        end
        enable = 1'b0;
        repeat (3) @(negedge sample_clk);
    endtask

    task automatic test_mask_101();
        int n;
        bit to;
        logic [1:0] exp_pad [5];
        logic [1:0] exp_seq [5];
        int bad;
        exp_pad = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        pad_mask = 3'b101;
        cmp_data = 3'b101;
        tx_ready = 1'b1;
        enable = 1'b1;
        bad = 0;
        for (int w = 0; w < 5; w++) begin
            wait_valid(200, n, to);
            tests++;
            if (to || tx_data[79:72] !== {4'hA, exp_pad[w], exp_seq[w]}
                || tx_data[71:0] !== {72{1'b1}} || cur_pad !== exp_pad[w]) begin
                fails++;
                $display("FAIL mask101_w%0d got hdr=%h pad=%0d want %h", w,
                         tx_data[79:72], cur_pad, {4'hA, exp_pad[w], exp_seq[w]});
            end
        end
        enable = 1'b0;
        repeat (3) @(negedge sample_clk);
    endtask

    task automatic test_stall();
        int i;
        int bad;
        int badtd;
        int wd;
        bit to;
        logic [71:0] pat;
        logic [79:0] exp;
        pat = 72'h12_3456_789A_BCDE_F0F1;
        exp = {8'hA0, pat};
        do_reset();
        pad_mask = 3'b001;
        cmp_data = 3'b000;
        tx_ready = 1'b0;
        enable = 1'b1;
        @(negedge sample_clk);
        i = 0;
        to = 1'b1;
        while (i < 200) begin
            cmp_data = (i >= 7 && i <= 78) ? {2'b00, pat[7'(78 - i)]} : 3'b000;
            @(negedge sample_clk);
            i++;
            if (tx_valid) begin
                to = 1'b0;
                break;
            end
        end
        cmp_data = 3'b000;
        tests++;
        if (to || i != 79 || tx_data !== exp) begin
            fails++;
            $display("FAIL capture_order got %h lat=%0d want %h lat=79", tx_data, i, exp);
        end
        bad = 0;
        badtd = 0;
        wd = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge sample_clk);
            if (tx_data !== exp || tx_valid !== 1'b1) bad++;
            if (word_done) wd++;
            if (T !== 1'b1 || D !== 1'b0) badtd++;
        end
        tests++;
        if (bad != 0 || wd != 0) begin
            fails++;
            $display("FAIL stall_hold got unstable=%0d wd=%0d want 0 0", bad, wd);
        end
        tests++;
        if (badtd != 0) begin
            fails++;
            $display("FAIL stall_td got bad=%0d want 0", badtd);
        end
        tx_ready = 1'b1;
        wd = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge sample_clk);
            if (word_done) wd++;
        end
        tests++;
        if (wd != 1) begin
            fails++;
            $display("FAIL stall_word_done got %0d pulses want 1", wd);
        end
        enable = 1'b0;
        wait_idle(200, to);
    endtask

    task automatic test_enable_drop();
        int n;
        int cnt;
        bit to;
        do_reset();
        pad_mask = 3'b111;
        cmp_data = 3'b000;
        tx_ready = 1'b1;
        enable = 1'b1;
        @(negedge sample_clk);
        repeat (30) @(negedge sample_clk);
        enable = 1'b0;
        wait_valid(200, n, to);
        tests++;
        if (to || n + 30 != 79) begin
            fails++;
            $display("FAIL drop_emit got lat=%0d timeout=%0d want 79 0", n + 30, to);
        end
        repeat (2) @(negedge sample_clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL drop_idle got busy=%b want 0", busy);
        end
        enable = 1'b1;
        pad_mask = 3'b000;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge sample_clk);
            if (busy || tx_valid) cnt++;
        end
        tests++;
        if (cnt != 0) begin
            fails++;
            $display("FAIL mask_zero got active=%0d want 0", cnt);
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid_drive();
        int n;
        bit to;
        do_reset();
        pad_mask = 3'b111;
        cmp_data = 3'b000;
        tx_ready = 1'b1;
        enable = 1'b1;
        wait_valid(200, n, to);
        @(negedge sample_clk);
        @(negedge sample_clk);
        tests++;
        if (to || T !== 1'b0 || D !== 1'b1) begin
            fails++;
            $display("FAIL pre_rst_drive got T=%b D=%b want 0 1", T, D);
        end
        sample_rst_n = 1'b0;
        @(negedge sample_clk);
        tests++;
        if (T !== 1'b1 || D !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst got T=%b D=%b v=%b busy=%b want 1 0 0 0",
                     T, D, tx_valid, busy);
        end
        sample_rst_n = 1'b1;
        @(negedge sample_clk);
        wait_valid(200, n, to);
        tests++;
        if (to || n != 79 || tx_data[79:72] !== 8'hA0) begin
            fails++;
            $display("FAIL post_rst_word got hdr=%h lat=%0d want A0 79", tx_data[79:72], n);
        end
        enable = 1'b0;
        wait_idle(200, to);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        sample_rst_n = 1'b0;
        enable = 1'b0;
        pad_mask = 3'b000;
        cmp_data = 3'b000;
        tx_ready = 1'b0;
        test_reset();
        test_first_words();
        test_td_waveform();
        test_mask_101();
        test_stall();
        test_enable_drop();
        test_reset_mid_drive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
